// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the reset/lock handshake of the audio clock PLL from the
//   free-running reference clock. The PLL is held in reset, then given a
//   bounded window to lock. Lock must stay stable for a set time before the
//   downstream reset is released. On a lock timeout the PLL is retried; after
//   too many consecutive timeouts the block parks in FAIL. A lock loss while
//   running re-enters the reset sequence and is recorded in sticky status.
//
// Ports
//   clk          in   reference clock (free running)
//   reset_n      in   synchronous active-low reset
//   pll_locked   in   PLL lock output, asynchronous to clk
//   clear_status in   pulse: clears lock_lost and relock_count
//   pll_rst      out  active-high PLL reset
//   sys_reset_n  out  active-low reset for PLL-clocked logic
//   lock_lost    out  sticky: lock dropped while running
//   relock_count out  saturating count of lock-loss events
//   pll_fail     out  retries exhausted
//   state_o      out  ASSERT=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       clear_status,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       lock_lost,
    output logic [7:0] relock_count,
    output logic       pll_fail,
    output logic [2:0] state_o
);

    localparam int unsigned MAX_RS = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int unsigned MAXC   = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
    localparam int unsigned CW     = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {
        S_ASSERT = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retry_q, retry_d;
    logic          sync1_q, lk_q;
    logic          pll_rst_q, sys_rst_n_q, pll_fail_q;
    logic          lock_lost_q, lock_lost_d;
    logic [7:0]    relock_q, relock_d;
    logic          lost_ev;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        lost_ev = 1'b0;
        case (state_q)
            S_ASSERT: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) state_d = S_ASSERT == S_ASSERT ? S_WAIT : S_WAIT;
            end
            S_WAIT: begin
                if (lk_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + 8'd1;
                    state_d = (retry_d == 8'(MAX_RETRIES)) ? S_FAIL : S_ASSERT;
                end
            end
            S_STABLE: begin
                // A lock glitch restarts the wait window without consuming a retry.
                if (!lk_q) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lk_q) begin
                    state_d = S_ASSERT;
                    lost_ev = 1'b1;
                end
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_ASSERT;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;

        // A lock-loss event in the same cycle as a clear wins over the clear.
        lock_lost_d = lock_lost_q;
        relock_d    = relock_q;
        if (lost_ev) begin
            lock_lost_d = 1'b1;
            if (clear_status)           relock_d = 8'd1;
            else if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end else if (clear_status) begin
            lock_lost_d = 1'b0;
            relock_d    = '0;
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_ASSERT;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync1_q     <= 1'b0;
            lk_q        <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
            relock_q    <= '0;
            pll_fail_q  <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            lk_q        <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == S_ASSERT) || (state_d == S_FAIL);
            sys_rst_n_q <= (state_d == S_RUN);
            pll_fail_q  <= (state_d == S_FAIL);
            lock_lost_q <= lock_lost_d;
            relock_q    <= relock_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset_n  = sys_rst_n_q;
    assign lock_lost    = lock_lost_q;
    assign relock_count = relock_q;
    assign pll_fail     = pll_fail_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

    localparam int unsigned RST = 4;
    localparam int unsigned TO  = 100;
    localparam int unsigned ST  = 8;
    localparam int unsigned MR  = 3;
    localparam logic [14:0] RESET_VEC = 15'h4000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       clear_status = 1'b0;
    logic       pll_rst, sys_reset_n, lock_lost, pll_fail;
    logic [7:0] relock_count;
    logic [2:0] state_o;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(ST),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .clear_status(clear_status),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .lock_lost   (lock_lost),
        .relock_count(relock_count),
        .pll_fail    (pll_fail),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    // Reference model: phase number, time spent in phase, timeout tally,
    // sticky status, and a two-deep delay line standing in for the synchronizer.
    localparam int P_ASSERT = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;
    int   m_phase = P_ASSERT;
    int   m_t     = 0;
    int   m_tries = 0;
    logic m_lost  = 1'b0;
    int   m_rc    = 0;
    logic m_dl[$];

    function automatic void model_step(input logic rn, input logic pl, input logic clr);
        logic lk;
        int   nxt;
        logic ev;
        if (!rn) begin
            m_phase = P_ASSERT; m_t = 0; m_tries = 0; m_lost = 1'b0; m_rc = 0;
            m_dl = '{1'b0, 1'b0};
            return;
        end
        lk  = m_dl.pop_front();
        m_dl.push_back(pl);
        nxt = m_phase;
        ev  = 1'b0;
        case (m_phase)
            P_ASSERT: if (m_t + 1 == int'(RST)) nxt = P_WAIT;
            P_WAIT: begin
                if (lk) nxt = P_STABLE;
                else if (m_t + 1 == int'(TO)) begin
                    m_tries++;
                    nxt = (m_tries == int'(MR)) ? P_FAIL : P_ASSERT;
                end
            end
            P_STABLE: begin
                if (!lk) nxt = P_WAIT;
                else if (m_t + 1 == int'(ST)) begin nxt = P_RUN; m_tries = 0; end
            end
            P_RUN: if (!lk) begin nxt = P_ASSERT; ev = 1'b1; end
            default: nxt = m_phase;
        endcase
        if (ev) begin
            m_lost = 1'b1;
            m_rc   = clr ? 1 : ((m_rc < 255) ? m_rc + 1 : 255);
        end else if (clr) begin
            m_lost = 1'b0;
            m_rc   = 0;
        end
        m_t     = (nxt != m_phase) ? 0 : m_t + 1;
        m_phase = nxt;
    endfunction

    function automatic logic [14:0] exp_vec();
        return {(m_phase == P_ASSERT) || (m_phase == P_FAIL), m_phase == P_RUN, m_lost,
                8'(m_rc), m_phase == P_FAIL, 3'(m_phase)};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {pll_rst, sys_reset_n, lock_lost, relock_count, pll_fail, state_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset_n, pll_locked, clear_status);
        cyc++;
        #1;
        check("outputs", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin tick(); n++; end
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic bringup(input string tag);
        int n;
        reset_n = 1'b0; pll_locked = 1'b0; clear_status = 1'b0;
        repeat (2) tick();
        check({tag, "_reset_vec"}, 32'(obs_vec()), 32'(RESET_VEC));
        reset_n = 1'b1;
        n = 1;
        tick();
        while (pll_rst && n < 50) begin tick(); n++; end
        check({tag, "_pll_rst_len"}, 32'(n), 32'(RST));
        repeat (20 - RST) tick();
        pll_locked = 1'b1;
        n = 0;
        while (!sys_reset_n && n < 200) begin tick(); n++; end
        check({tag, "_lock_to_run"}, 32'(n), 32'(2 + 1 + ST));
        check({tag, "_in_run"}, 32'(state_o), 32'(3));
    endtask

    initial begin
        int n;

        // Normal bring-up
        bringup("bringup");

        // Lock glitch in STABLE after 5 stable cycles
        reset_n = 1'b0; pll_locked = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_state(3'd2, 50, "glitch_enter_stable");
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_state(3'd1, 10, "glitch_back_to_wait");
        check("glitch_sys_rst_low", 32'(sys_reset_n), 32'(0));
        wait_state(3'd2, 10, "glitch_restable");
        n = 0;
        while (state_o === 3'd2 && n < 50) begin tick(); n++; end
        check("glitch_full_stable", 32'(n), 32'(ST));
        check("glitch_run", 32'(sys_reset_n), 32'(1));

        // Lock loss in RUN
        pll_locked = 1'b0;
        repeat (2) tick();
        check("loss_still_run", 32'(sys_reset_n), 32'(1));
        tick();
        check("loss_sys_rst", 32'(sys_reset_n), 32'(0));
        check("loss_pll_rst", 32'(pll_rst), 32'(1));
        check("loss_lock_lost", 32'(lock_lost), 32'(1));
        check("loss_relock_count", 32'(relock_count), 32'(1));
        pll_locked = 1'b1;
        wait_state(3'd3, 100, "loss_relock_run");
        for (int i = 1; i < 256; i++) begin
            pll_locked = 1'b0;
            repeat ($urandom_range(1, 5)) tick();
            pll_locked = 1'b1;
            repeat (3) tick();
            wait_state(3'd3, 100, "sat_relock_run");
            repeat ($urandom_range(0, 3)) tick();
        end
        check("relock_saturated", 32'(relock_count), 32'(255));

        // clear_status alone, then coincident with a lock drop
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clear_lock_lost", 32'(lock_lost), 32'(0));
        check("clear_relock_count", 32'(relock_count), 32'(0));
        pll_locked = 1'b0;
        repeat (2) tick();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clear_vs_event_lost", 32'(lock_lost), 32'(1));
        check("clear_vs_event_count", 32'(relock_count), 32'(1));
        pll_locked = 1'b1;
        wait_state(3'd3, 100, "clear_relock_run");

        // Timeouts into FAIL
        reset_n = 1'b0; pll_locked = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (state_o !== 3'd4 && n < 600) begin tick(); n++; end
        check("timeout_cycles_to_fail", 32'(n), 32'(MR * (RST + TO)));
        check("fail_flag", 32'(pll_fail), 32'(1));
        for (int i = 0; i < 40; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            tick();
        end
        check("fail_sticky_state", 32'(state_o), 32'(4));
        check("fail_pll_rst", 32'(pll_rst), 32'(1));

        // Reset mid-WAIT_LOCK and mid-RUN
        reset_n = 1'b0; pll_locked = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_state(3'd1, 20, "midwait_enter");
        repeat (50) tick();
        reset_n = 1'b0;
        tick();
        check("midwait_reset_vec", 32'(obs_vec()), 32'(RESET_VEC));
        bringup("rebringup");
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        wait_state(3'd3, 100, "midrun_relock");
        reset_n = 1'b0;
        tick();
        check("midrun_reset_vec", 32'(obs_vec()), 32'(RESET_VEC));
        reset_n = 1'b1;

        // Randomized segments against the model
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            len        = $urandom_range(1, 40);
            pll_locked = ($urandom_range(0, 3) != 0);
            reset_n    = ($urandom_range(0, 40) != 0);
            for (int k = 0; k < len; k++) begin
                clear_status = ($urandom_range(0, 19) == 0);
                tick();
                reset_n = 1'b1;
            end
        end
        clear_status = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the reset/lock handshake of the audio clock PLL (50 MHz reference in, 11.289 MHz audio and ~49.77 MHz system clocks out).
- Drives the PLL's active-high reset and monitors its asynchronous lock output.
- Releases the downstream reset only after lock has been stable for a set time, and retries the PLL on lock timeout or lock loss.
- Runs on the free-running 50 MHz reference clock, so it operates before the PLL outputs exist.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before retrying (>=1).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (>=1).
- MAX_RETRIES, 7: consecutive timeouts tolerated before entering FAIL (1..255).

Ports:
- clk, in, 1: 50 MHz free-running reference clock.
- reset_n, in, 1: synchronous active-low reset.
- pll_locked, in, 1: PLL lock output, asynchronous to clk.
- clear_status, in, 1: synchronous pulse that clears lock_lost and relock_count.
- pll_rst, out, 1: active-high PLL reset.
- sys_reset_n, out, 1: active-low reset for logic clocked by the PLL outputs.
- lock_lost, out, 1: sticky flag; lock dropped while in RUN.
- relock_count, out, 8: saturating count of lock-loss events.
- pll_fail, out, 1: retries exhausted.
- state_o, out, 3: encoded state, ASSERT=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low (reset_n). All outputs are registered.
- On any clk edge with reset_n=0:
  - state=ASSERT, cnt=0, retry=0, sync flops=0.
  - pll_rst=1, sys_reset_n=0, lock_lost=0, relock_count=0, pll_fail=0.
- pll_locked passes through a 2-flop synchronizer to give lk; lk lags pll_locked by 2 cycles. Only lk is used internally.
- One shared counter, cnt, sized $clog2 of the largest of the three cycle parameters plus 1. cnt clears on every state change.
- ASSERT:
  - pll_rst=1, sys_reset_n=0.
  - Go to WAIT_LOCK when cnt==RST_CYCLES-1. pll_rst is high exactly RST_CYCLES cycles after reset release.
- WAIT_LOCK:
  - pll_rst=0, sys_reset_n=0.
  - lk=1: go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1: retry+=1. If the new retry==MAX_RETRIES go to FAIL, else go to ASSERT.
- STABLE:
  - pll_rst=0, sys_reset_n=0.
  - lk=0: go to WAIT_LOCK with a fresh timeout. A glitch does not count as a retry.
  - Else if cnt==STABLE_CYCLES-1: go to RUN and set retry=0.
- RUN:
  - pll_rst=0, sys_reset_n=1. sys_reset_n rises on the same edge that enters RUN.
  - lk=0: go to ASSERT; sys_reset_n=0 and pll_rst=1 on that same edge; lock_lost=1; relock_count+=1, saturating at 255.
- FAIL:
  - pll_rst=1, sys_reset_n=0, pll_fail=1.
  - The only exit is reset_n=0.
- clear_status=1:
  - Clears lock_lost and relock_count on the next edge.
  - If a lock-loss event occurs in the same cycle, the event wins: lock_lost=1, relock_count=1.
- reset_n asserted in any state, mid-count included, forces the reset values on the next edge. The retry counter is cleared too.
- pll_locked toggling while in ASSERT or FAIL is ignored.

Test Plan:
All tests use RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=3.
1. Normal bring-up: release reset_n, raise pll_locked 20 cycles later and hold it.
   - pll_rst is high exactly 4 cycles.
   - sys_reset_n rises 2 (sync) + 1 + 8 cycles after pll_locked rises.
   - state_o goes 0→1→2→3.
2. Lock glitch: in STABLE, drop pll_locked for 1 cycle after 5 stable cycles.
   - state returns to WAIT_LOCK.
   - Re-lock requires a full 8 stable cycles.
   - sys_reset_n stays 0; retry is not incremented.
3. Timeouts: hold pll_locked=0.
   - Three ASSERT(4)/WAIT_LOCK(100) sequences occur.
   - pll_fail=1 and state_o=4 after the third timeout.
   - pll_rst stays 1 until reset_n is asserted.
4. Lock loss in RUN: drop pll_locked.
   - sys_reset_n=0 and pll_rst=1, 3 cycles after the drop (2 sync + 1).
   - lock_lost=1, relock_count=1.
   - Relock reaches RUN again.
   - Repeat 256 drops: relock_count saturates at 255.
5. clear_status pulse while lock_lost=1 with no event → lock_lost=0, relock_count=0. Pulse coincident with a RUN lock drop → lock_lost=1, relock_count=1.
6. Assert reset_n=0 mid-WAIT_LOCK (cnt=50) and mid-RUN → all outputs return to reset values on the next edge; the following bring-up matches test 1.
